// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: one buffered slot per
// producer (ALU, load, MDU), round-robin grant, registered write port and pending mask.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [AW-1:0]      alu_addr,
  input  logic [DW-1:0]      alu_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [AW-1:0]      ld_addr,
  input  logic [DW-1:0]      ld_data,
  input  logic               md_valid,
  output logic               md_ready,
  input  logic [AW-1:0]      md_addr,
  input  logic [DW-1:0]      md_data,
  output logic               wr,
  output logic [AW-1:0]      addr_w,
  output logic [DW-1:0]      data_w,
  output logic [(1<<AW)-1:0] pending,
  output logic [1:0]         grant_id
);

  localparam int NP = 3;
  localparam int NR = 1 << AW;

  logic [NP-1:0] in_v;
  logic [AW-1:0] in_a [NP];
  logic [DW-1:0] in_d [NP];

  logic [NP-1:0] slot_v_q, slot_v_d;
  logic [AW-1:0] slot_a_q [NP];
  logic [AW-1:0] slot_a_d [NP];
  logic [DW-1:0] slot_d_q [NP];
  logic [DW-1:0] slot_d_d [NP];
  logic [1:0]    ptr_q, ptr_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_w_q, addr_w_d;
  logic [DW-1:0] data_w_q, data_w_d;
  logic [1:0]    gid_q, gid_d;
  logic [NR-1:0] pending_q, pending_d;

  logic [NP-1:0] gnt, conflict, ready;
  logic          gnt_any;
  logic [1:0]    gnt_idx, c1, c2;

  // Gather producer ports into indexable arrays
  always_comb begin
    in_v    = {md_valid, ld_valid, alu_valid};
    in_a[0] = alu_addr;
    in_a[1] = ld_addr;
    in_a[2] = md_addr;
    in_d[0] = alu_data;
    in_d[1] = ld_data;
    in_d[2] = md_data;
  end

  // Round-robin search: ptr, ptr+1, ptr+2 (mod 3)
  always_comb begin
    c1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    c2 = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    if (slot_v_q[ptr_q]) begin
      gnt_any = 1'b1;
      gnt_idx = ptr_q;
    end else if (slot_v_q[c1]) begin
      gnt_any = 1'b1;
      gnt_idx = c1;
    end else if (slot_v_q[c2]) begin
      gnt_any = 1'b1;
      gnt_idx = c2;
    end else begin
      gnt_any = 1'b0;
      gnt_idx = 2'd3;
    end
    gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
  end

  // A held, ungranted write to the same register blocks a newer producer
  always_comb begin
    conflict = 3'b000;
    ready    = 3'b000;
    for (int k = 0; k < NP; k++) begin
      for (int j = 0; j < NP; j++) begin
        conflict[k] = conflict[k] |
                      ((j != k) && slot_v_q[j] && !gnt[j] && (slot_a_q[j] == in_a[k]));
      end
      ready[k] = reset & (~slot_v_q[k] | gnt[k]) & ~conflict[k];
    end
  end

  assign alu_ready = ready[0];
  assign ld_ready  = ready[1];
  assign md_ready  = ready[2];

  // Slot, pointer, output-stage and pending next state
  always_comb begin
    slot_v_d = slot_v_q;
    for (int k = 0; k < NP; k++) begin
      slot_a_d[k] = slot_a_q[k];
      slot_d_d[k] = slot_d_q[k];
      if (in_v[k] && ready[k] && (in_a[k] != {AW{1'b0}})) begin
        slot_v_d[k] = 1'b1;
        slot_a_d[k] = in_a[k];
        slot_d_d[k] = in_d[k];
      end else if (gnt[k]) begin
        slot_v_d[k] = 1'b0;
      end else begin
        slot_v_d[k] = slot_v_q[k];
      end
    end
    if (gnt_any) begin
      wr_d     = 1'b1;
      addr_w_d = slot_a_q[gnt_idx];
      data_w_d = slot_d_q[gnt_idx];
      gid_d    = gnt_idx;
      ptr_d    = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end else begin
      wr_d     = 1'b0;
      addr_w_d = addr_w_q;
      data_w_d = data_w_q;
      gid_d    = 2'd3;
      ptr_d    = ptr_q;
    end
    pending_d = {NR{1'b0}};
    for (int k = 0; k < NP; k++) begin
      pending_d[slot_a_d[k]] = pending_d[slot_a_d[k]] | slot_v_d[k];
    end
    pending_d[addr_w_d] = pending_d[addr_w_d] | wr_d;
    pending_d[0]        = 1'b0;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_v_q  <= 3'b000;
      ptr_q     <= 2'd0;
      wr_q      <= 1'b0;
      addr_w_q  <= {AW{1'b0}};
      data_w_q  <= {DW{1'b0}};
      gid_q     <= 2'd3;
      pending_q <= {NR{1'b0}};
      for (int k = 0; k < NP; k++) begin
        slot_a_q[k] <= {AW{1'b0}};
        slot_d_q[k] <= {DW{1'b0}};
      end
    end else begin
      slot_v_q  <= slot_v_d;
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      addr_w_q  <= addr_w_d;
      data_w_q  <= data_w_d;
      gid_q     <= gid_d;
      pending_q <= pending_d;
      for (int k = 0; k < NP; k++) begin
        slot_a_q[k] <= slot_a_d[k];
        slot_d_q[k] <= slot_d_d[k];
      end
    end
  end

  assign wr       = wr_q;
  assign addr_w   = addr_w_q;
  assign data_w   = data_w_q;
  assign grant_id = gid_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, md_valid;
  logic        alu_ready, ld_ready, md_ready;
  logic [4:0]  alu_addr, ld_addr, md_addr;
  logic [31:0] alu_data, ld_data, md_data;
  logic        wr;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [31:0] pending;
  logic [1:0]  grant_id;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  g;
  } wb_t;

  wb_t  exp_q[$];
  wb_t  mon_e;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .wr(wr), .addr_w(addr_w), .data_w(data_w), .pending(pending), .grant_id(grant_id)
  );

  // Monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (wr) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h gid=%0d, expected no write",
                   addr_w, data_w, grant_id);
        end else begin
          mon_e = exp_q.pop_front();
          if ({addr_w, data_w, grant_id} !== {mon_e.a, mon_e.d, mon_e.g}) begin
            errors++;
            $display("FAIL write_data: got addr=%0d data=%h gid=%0d, expected addr=%0d data=%h gid=%0d",
                     addr_w, data_w, grant_id, mon_e.a, mon_e.d, mon_e.g);
          end
        end
      end else if (grant_id !== 2'd3) begin
        errors++;
        $display("FAIL idle_gid: got %0d expected 3", grant_id);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] pa, input logic [31:0] pd, input logic [1:0] pg);
    exp_q.push_back('{pa, pd, pg});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    md_valid  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [2:0]  rdy, exp_rdy;
  logic [31:0] dat [3];

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b0;
    alu_addr = 5'd0; ld_addr = 5'd0; md_addr = 5'd0;
    alu_data = 32'd0; ld_data = 32'd0; md_data = 32'd0;
    step();
    step();
    neg();
    chk("reset_wr", wr, 1'b0);
    chk("reset_gid", grant_id, 2'd3);
    chk("reset_pending", pending, 32'd0);
    chk("reset_ready", {md_ready, ld_ready, alu_ready}, 3'b000);
    mon_en = 1'b1;
    step();
    reset = 1'b1;

    // Single write
    step();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF, 2'd0);
    neg(); chk("single_ready", alu_ready, 1'b1);
    step(); alu_valid = 1'b0;
    neg(); chk("single_pend_e1", pending[5], 1'b1); chk("single_wr_e1", wr, 1'b0);
    step();
    neg(); chk("single_wr_e2", wr, 1'b1); chk("single_pend_e2", pending[5], 1'b1);
    step();
    neg(); chk("single_pend_e3", pending[5], 1'b0); chk("single_wr_e3", wr, 1'b0);
    idle(3);

    // Round-robin with all three continuously valid
    do_reset();
    for (int k = 0; k < 3; k++) dat[k] = 32'h1000_0000 * (k + 1);
    alu_addr = 5'd1; ld_addr = 5'd2; md_addr = 5'd3;
    alu_valid = 1'b1; ld_valid = 1'b1; md_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      alu_data = dat[0]; ld_data = dat[1]; md_data = dat[2];
      exp_rdy = (i == 0) ? 3'b111 : (3'b001 << ((i - 1) % 3));
      neg();
      rdy = {md_ready, ld_ready, alu_ready};
      chk("rr_ready", rdy, exp_rdy);
      for (int k = 0; k < 3; k++) begin
        if (exp_rdy[k]) push(5'(k + 1), dat[k], 2'(k));
      end
      step();
      for (int k = 0; k < 3; k++) begin
        if (exp_rdy[k]) dat[k] = dat[k] + 32'd1;
      end
    end
    idle(8);

    // Ordering conflict on register 7
    do_reset();
    ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'h0000_0444;
    push(5'd4, 32'h0000_0444, 2'd1);
    step();
    ld_addr = 5'd7; ld_data = 32'hAAAA_0007;
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h9999_0009;
    push(5'd9, 32'h9999_0009, 2'd2);
    push(5'd7, 32'hAAAA_0007, 2'd1);
    neg(); chk("conf_ld_ready", ld_ready, 1'b1); chk("conf_md_ready", md_ready, 1'b1);
    step();
    ld_valid = 1'b0; md_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hBBBB_0007;
    neg(); chk("conf_alu_blocked", alu_ready, 1'b0); chk("conf_pending", pending, 32'h0000_0290);
    step();
    neg(); chk("conf_alu_released", alu_ready, 1'b1);
    push(5'd7, 32'hBBBB_0007, 2'd0);
    step();
    idle(8);

    // Register 0 writes are swallowed
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'h5555_5555;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) md_valid = 1'b0;
      neg();
      if (i < 4) chk("r0_ready", md_ready, 1'b1);
      chk("r0_wr", wr, 1'b0);
      chk("r0_pending", pending, 32'd0);
      step();
    end

    // Back-to-back stream from the load unit
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        ld_valid = 1'b1; ld_addr = 5'(10 + i); ld_data = 32'hC0DE_0000 + 32'(i);
        push(5'(10 + i), 32'hC0DE_0000 + 32'(i), 2'd1);
      end else begin
        ld_valid = 1'b0;
      end
      neg();
      if (i < 8) chk("b2b_ready", ld_ready, 1'b1);
      chk("b2b_wr", wr, (i >= 2 && i <= 9) ? 1'b1 : 1'b0);
      step();
    end
    idle(4);

    // Reset with all slots full: nothing buffered may be written
    alu_valid = 1'b1; ld_valid = 1'b1; md_valid = 1'b1;
    alu_addr = 5'd20; ld_addr = 5'd21; md_addr = 5'd22;
    alu_data = 32'h2020_2020; ld_data = 32'h2121_2121; md_data = 32'h2222_2222;
    neg(); chk("mid_fill_ready", {md_ready, ld_ready, alu_ready}, 3'b111);
    step();
    alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b0;
    reset = 1'b0;
    neg(); chk("mid_rst_ready", {md_ready, ld_ready, alu_ready}, 3'b000);
    step();
    reset = 1'b1;
    neg();
    chk("mid_rst_wr", wr, 1'b0);
    chk("mid_rst_gid", grant_id, 2'd3);
    chk("mid_rst_pending", pending, 32'd0);
    alu_valid = 1'b1; ld_valid = 1'b1; md_valid = 1'b1;
    alu_addr = 5'd24; ld_addr = 5'd25; md_addr = 5'd26;
    push(5'd24, 32'h2020_2020, 2'd0);
    push(5'd25, 32'h2121_2121, 2'd1);
    push(5'd26, 32'h2222_2222, 2'd2);
    step();
    idle(8);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
